// File: rtl/odd_seq_monitor.sv
// Checks that a 4-bit odd-value counter follows the ring 1->3->5->7->9->1.
// Tracks lock, completed laps, per-lap sums and sequence errors.
module odd_seq_monitor #(
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned LAP_W    = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       count_in,
  input  logic             clear,
  output logic             locked,
  output logic             lap_done,
  output logic [LAP_W-1:0] lap_count,
  output logic [4:0]       lap_sum,
  output logic [4:0]       lap_sum_last,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned      RUN_W   = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             seen_one_q, seen_one_d;
  logic [4:0]       lap_sum_q, lap_sum_d;
  logic [4:0]       lap_sum_last_q, lap_sum_last_d;
  logic [LAP_W-1:0] lap_count_q, lap_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             lap_done_q, lap_done_d;
  logic             seq_err_q, seq_err_d;
  logic             legal;

  function automatic logic is_legal(input logic [3:0] from_v, input logic [3:0] to_v);
    logic ok;
    case (from_v)
      4'd1:    ok = (to_v == 4'd3);
      4'd3:    ok = (to_v == 4'd5);
      4'd5:    ok = (to_v == 4'd7);
      4'd7:    ok = (to_v == 4'd9);
      4'd9:    ok = (to_v == 4'd1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign legal = is_legal(prev_q, count_in);

  always_comb begin
    state_d        = state_q;
    prev_d         = count_in;
    prev_valid_d   = 1'b1;
    run_d          = run_q;
    seen_one_d     = seen_one_q;
    lap_sum_d      = lap_sum_q;
    lap_sum_last_d = lap_sum_last_q;
    lap_count_d    = lap_count_q;
    err_count_d    = err_count_q;
    lap_done_d     = 1'b0;
    seq_err_d      = 1'b0;

    // The very first sample after reset has no predecessor to compare with.
    if (prev_valid_q) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (legal) begin
            run_d = run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) == RUN_MAX) begin
              state_d    = ST_LOCKED;
              seen_one_d = 1'b0;
              lap_sum_d  = 5'd0;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (legal) begin
            if (count_in == 4'd1) begin
              // A lap only counts once a full ring has been observed from a 1.
              if (seen_one_q) begin
                lap_done_d     = 1'b1;
                lap_count_d    = lap_count_q + LAP_W'(1);
                lap_sum_last_d = lap_sum_q;
              end
              lap_sum_d  = 5'd1;
              seen_one_d = 1'b1;
            end else begin
              lap_sum_d = lap_sum_q + {1'b0, count_in};
            end
          end else begin
            seq_err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            state_d    = ST_UNLOCKED;
            run_d      = '0;
            lap_sum_d  = 5'd0;
            seen_one_d = 1'b0;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end

    if (clear) begin
      lap_count_d    = '0;
      err_count_d    = '0;
      lap_sum_last_d = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNLOCKED;
      prev_q         <= 4'd0;
      prev_valid_q   <= 1'b0;
      run_q          <= '0;
      seen_one_q     <= 1'b0;
      lap_sum_q      <= 5'd0;
      lap_sum_last_q <= 5'd0;
      lap_count_q    <= '0;
      err_count_q    <= '0;
      lap_done_q     <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      prev_valid_q   <= prev_valid_d;
      run_q          <= run_d;
      seen_one_q     <= seen_one_d;
      lap_sum_q      <= lap_sum_d;
      lap_sum_last_q <= lap_sum_last_d;
      lap_count_q    <= lap_count_d;
      err_count_q    <= err_count_d;
      lap_done_q     <= lap_done_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign locked       = (state_q == ST_LOCKED);
  assign lap_done     = lap_done_q;
  assign lap_count    = lap_count_q;
  assign lap_sum      = lap_sum_q;
  assign lap_sum_last = lap_sum_last_q;
  assign seq_err      = seq_err_q;
  assign err_count    = err_count_q;

endmodule

// File: doc/odd_seq_monitor.md
# odd_seq_monitor

Downstream consumer of the odd-value counter. Samples its 4-bit output every clock and checks that it follows the ring 1→3→5→7→9→1. Acquires lock after a run of legal transitions, counts completed laps, accumulates the per-lap sum (25 for a clean lap), and flags and counts sequence errors. Used as an on-chip checker and as the lap-rate source for status logic.

## Interface
- LOCK_LEN, 2: consecutive legal transitions needed to assert lock (≥1).
- LAP_W, 8: lap counter width.
- ERR_W, 8: error counter width.

- clk  in  1  rising-edge clock, same clock as the counter.
- rst_n  in  1  asynchronous active-low reset.
- count_in  in  4  counter output, sampled each rising edge.
- clear  in  1  synchronous clear of lap_count, err_count and lap_sum_last.
- locked  out  1  sequence lock indicator.
- lap_done  out  1  one-cycle pulse per completed full lap.
- lap_count  out  LAP_W  completed laps, wraps modulo 2^LAP_W.
- lap_sum  out  5  running sum of the current lap.
- lap_sum_last  out  5  lap_sum captured at the last lap_done.
- seq_err  out  1  one-cycle pulse on an illegal transition while locked.
- err_count  out  ERR_W  errors seen while locked, saturating.

## Operation
- Successor function: 1→3, 3→5, 5→7, 7→9, 9→1. Any other pair, including pairs with an out-of-set value (0, evens, >9), is illegal.
- Internal state: prev (4 b), prev_valid, run counter (0..LOCK_LEN), seen_one, FSM {UNLOCKED, LOCKED}.
- First edge after reset: capture prev, set prev_valid. No transition is evaluated.
- Each later edge: evaluate prev→count_in, then set prev ← count_in.
- UNLOCKED:
  - Legal transition: run++. When run reaches LOCK_LEN, go to LOCKED with seen_one=0 and lap_sum=0.
  - Illegal transition: run=0. No seq_err, no err_count change.
- LOCKED, legal transition:
  - into 1: lap_sum←1. If seen_one=1, pulse lap_done, lap_count++ (wraps), lap_sum_last←lap_sum (pre-update value). Then set seen_one=1.
  - other values: lap_sum←lap_sum+count_in (max 25, fits 5 b).
- LOCKED, illegal transition: pulse seq_err, err_count++ (saturates at 2^ERR_W−1), go to UNLOCKED, run=0, lap_sum=0, seen_one=0, locked=0.
- clear has priority over increments in the same cycle:
  - lap_count, err_count and lap_sum_last go to 0.
  - The lap_done and seq_err pulses, FSM state and lap_sum still update normally.
- Reset values: locked 0, lap_done 0, lap_count 0, lap_sum 0, lap_sum_last 0, seq_err 0, err_count 0, prev_valid 0, run 0, seen_one 0, FSM UNLOCKED.

## Timing
- All outputs are registered. The result of a transition is visible immediately after the edge that samples the second value (latency 1 edge from count_in change).
- locked rises after the edge completing the LOCK_LEN-th legal transition. It falls after the edge that detects the error, the same edge on which seq_err pulses.
- lap_done and seq_err are high for exactly one cycle. They never assert in the same cycle.
- With LOCK_LEN=2 and a clean stream starting at 1 after reset, the first lap_done is at the 11th edge. It then repeats every 5 edges.
- rst_n assertion mid-lap clears all state immediately, without waiting for a clock edge. Deassertion is synchronous to clk (the synchronizer is external). The first edge after release is a capture-only edge.

## Test plan
- Clean stream 1,3,5,7,9,… from reset, LOCK_LEN=2 → locked=1 after edge 3; lap_done at edges 11, 16, 21; lap_sum_last=25; lap_count=1, 2, 3; seq_err never asserts.
- Locked, inject 4 in place of 5 → seq_err one cycle, err_count=1, locked=0. Stream 1,3,5 → no further errors; locked=1 after 3→5.
- ERR_W=2: five lock-then-glitch cycles → err_count reaches 3 and holds 3.
- LAP_W=2: five full laps after lock → lap_count sequence 1, 2, 3, 0, 1.
- clear asserted on the lap_done edge → lap_done=1, lap_count=0, lap_sum_last=0, lap_sum=1; next lap ends with lap_count=1.
- rst_n pulled low mid-lap (lap_sum=9, between edges) → all outputs 0 before the next edge. After release, feed 5,7,9,1,… → capture-only first edge; lock after 7→9; first lap_done on the second 9→1.
